// File: rtl/mips_multi.sv
// Multi-cycle MIPS subset core: FETCH -> DECODE -> EXEC -> MEM -> WB.
// One instruction is in flight at a time. HALT is entered on any unsupported
// instruction and is left only through reset.
//
// Memory handshake: mem_req is held with mem_we/mem_addr/mem_wdata stable
// until a rising edge where mem_req=1 and mem_ready=1. That edge completes
// the access, and mem_rdata is sampled on it. mem_ready is ignored while
// mem_req=0.
//
// dbg_state encoding: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT.
module mips_multi #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  localparam int RW = $clog2(NREGS);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] ir, a, b, alu_out, mdr, target;
  logic [31:0] rf [NREGS];

  logic [5:0]    opcode, funct;
  logic [RW-1:0] rs_idx, rt_idx, rd_idx, wb_idx;
  logic [31:0]   imm_sx, rf_a, rf_b, alu_b, alu_res, wb_data;
  logic          is_rtype, is_lw, is_sw, is_beq, is_bne, is_addi, is_j;
  logic          supported, branch_taken;

  // Instruction fields; index bits above log2(NREGS) are dropped.
  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  assign rs_idx = ir[21 +: RW];
  assign rt_idx = ir[16 +: RW];
  assign rd_idx = ir[11 +: RW];
  assign imm_sx = {{16{ir[15]}}, ir[15:0]};

  assign is_rtype = (opcode == OP_R) &&
                    (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                     funct == FN_OR  || funct == FN_SLT);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_j     = (opcode == OP_J);
  assign supported = is_rtype | is_lw | is_sw | is_beq | is_bne | is_addi | is_j;

  // Register 0 always reads as zero regardless of array contents.
  assign rf_a = (rs_idx == '0) ? 32'd0 : rf[rs_idx];
  assign rf_b = (rt_idx == '0) ? 32'd0 : rf[rt_idx];

  assign branch_taken = (is_beq && (a == b)) || (is_bne && (a != b));

  // R-type picks rd; addi and lw write rt. lw writes back the loaded word.
  assign wb_idx  = is_rtype ? rd_idx : rt_idx;
  assign wb_data = is_lw ? mdr : alu_out;

  // ALU: wrapping 32-bit arithmetic, slt is a signed compare.
  always_comb begin
    alu_b   = is_addi ? imm_sx : b;
    alu_res = a + alu_b;
    if (is_rtype) begin
      case (funct)
        FN_SUB:  alu_res = a - b;
        FN_AND:  alu_res = a & b;
        FN_OR:   alu_res = a | b;
        FN_SLT:  alu_res = {31'd0, ($signed(a) < $signed(b))};
        default: alu_res = a + b;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next state and state-decoded bus/retire outputs; the bus is held quiet
  // while reset is asserted even though state already reads FETCH.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_nxt = DECODE;
      end
      DECODE: begin
        if (!supported) state_nxt = HALT;
        else if (is_j) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end else state_nxt = EXEC;
      end
      EXEC: begin
        if (is_lw || is_sw) state_nxt = MEM;
        else if (is_beq || is_bne) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end else state_nxt = WB;
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_sw;
        mem_addr = alu_out;
        if (mem_ready) begin
          if (is_sw) begin
            retire    = 1'b1;
            state_nxt = FETCH;
          end else state_nxt = WB;
        end
      end
      WB: begin
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
    if (!reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
    end
  end

  assign mem_wdata = b;
  assign halted    = (state == HALT);
  assign dbg_state = state;

  // Datapath registers, pc and register file, updated per state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      target  <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        DECODE: begin
          a      <= rf_a;
          b      <= rf_b;
          // pc already holds the address of the next sequential instruction.
          target <= pc + {imm_sx[29:0], 2'b00};
          if (is_j) pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        EXEC: begin
          if (is_lw || is_sw) alu_out <= a + imm_sx;
          else                alu_out <= alu_res;
          if (branch_taken) pc <= target;
        end
        MEM: begin
          if (mem_ready && is_lw) mdr <= mem_rdata;
        end
        WB: begin
          if (wb_idx != '0) rf[wb_idx] <= wb_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multi.sv
// Directed testbench for mips_multi: small programs placed in a word-array
// memory model at RESET_PC, results observed through stores and the bus.
module tb_mips_multi;

  localparam logic [31:0] RPC    = 32'h0000_0040;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  logic        clk, reset, mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [2:0]  dbg_state;

  logic [31:0] mem [256];
  logic [31:0] exp_q [$];
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  int          errors = 0;
  int          checks = 0;
  int          retire_cnt = 0;
  int          pc_w = 16;

  mips_multi #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .pc(pc), .retire(retire), .halted(halted),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model and monitors ----------------
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (retire) retire_cnt++;
    if (reset && mem_req && mem_we && mem_ready) begin
      mem[mem_addr[9:2]] = mem_wdata;
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'b000000, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    pc_w = 16;
  endtask

  task automatic put(input logic [31:0] w);
    mem[pc_w] = w;
    pc_w++;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b0;
    mem_ready = rdy;
    wa_q.delete();
    wd_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic wait_retire(input int n, input int budget, output int cyc);
    int start;
    start = retire_cnt;
    cyc = 0;
    while ((retire_cnt - start) < n && cyc < budget) begin
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_mem();
    put(enc_i(OP_ADDI, 0, 1, 5));
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_bus: req=%b we=%b, want 0 0", mem_req, mem_we); end
    checks++; if (retire !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags: retire=%b halted=%b, want 0 0", retire, halted); end
    checks++; if (pc !== RPC || dbg_state !== 3'd0) begin errors++; $display("FAIL reset_pc: pc=%h state=%0d, want %h 0", pc, dbg_state, RPC); end
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RPC) begin errors++; $display("FAIL first_fetch: req=%b we=%b addr=%h, want 1 0 %h", mem_req, mem_we, mem_addr, RPC); end
    @(posedge clk);
    #1;
    checks++; if (pc !== 32'h44 || mem_req !== 1'b0) begin errors++; $display("FAIL decode_pc: pc=%h req=%b, want 00000044 0", pc, mem_req); end
  endtask

  task automatic test_program();
    int cyc;
    clear_mem();
    put(enc_i(OP_ADDI, 0, 1, 5));
    put(enc_i(OP_ADDI, 0, 2, -3));
    put(enc_r(1, 2, 3, FN_ADD));
    put(enc_i(OP_SW, 0, 3, 8));
    put(enc_i(OP_LW, 0, 4, 8));
    put(enc_i(OP_SW, 0, 4, 12));
    mem[2] = 32'h1111_1111;
    mem[3] = 32'h2222_2222;
    exp_q = {32'd2, 32'd2};
    do_reset(1'b1);
    wait_retire(5, 100, cyc);
    checks++; if (cyc !== 21) begin errors++; $display("FAIL prog_latency: cycles=%0d, want 21", cyc); end
    wait_retire(1, 20, cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL sw_latency: cycles=%0d, want 4", cyc); end
    checks++; if (wa_q.size() != 2 || wa_q[0] !== 32'd8 || wa_q[1] !== 32'd12) begin errors++; $display("FAIL prog_waddr: n=%0d first=%h, want 2 writes at 8,12", wa_q.size(), wa_q.size() > 0 ? wa_q[0] : 32'hx); end
    checks++; if (wd_q.size() != exp_q.size()) begin errors++; $display("FAIL prog_nwrites: got %0d, want %0d", wd_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wd_q.size(); i++) begin
      checks++; if (wd_q[i] !== exp_q[i]) begin errors++; $display("FAIL prog_wdata[%0d]: got %h, want %h", i, wd_q[i], exp_q[i]); end
    end
    checks++; if (mem[3] !== 32'd2) begin errors++; $display("FAIL lw_result: mem[12]=%h, want 00000002", mem[3]); end
  endtask

  task automatic test_branch();
    int cyc;
    clear_mem();
    put(enc_i(OP_BEQ, 0, 0, 3));
    do_reset(1'b1);
    wait_retire(1, 20, cyc);
    checks++; if (cyc !== 3 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h50) begin errors++; $display("FAIL beq_taken: cyc=%0d req=%b addr=%h, want 3 1 00000050", cyc, mem_req, mem_addr); end

    clear_mem();
    put(enc_i(OP_BNE, 0, 0, 3));
    do_reset(1'b1);
    wait_retire(1, 20, cyc);
    checks++; if (cyc !== 3 || mem_req !== 1'b1 || mem_addr !== 32'h44) begin errors++; $display("FAIL bne_not_taken: cyc=%0d req=%b addr=%h, want 3 1 00000044", cyc, mem_req, mem_addr); end

    clear_mem();
    put({6'b000010, 26'h20});
    do_reset(1'b1);
    wait_retire(1, 20, cyc);
    checks++; if (cyc !== 2 || mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL jump: cyc=%0d req=%b addr=%h, want 2 1 00000080", cyc, mem_req, mem_addr); end

    // addi at 0x40, then bne at 0x44 jumping back by two words to 0x40.
    clear_mem();
    put(enc_i(OP_ADDI, 0, 1, 1));
    put(enc_i(OP_BNE, 1, 0, -2));
    do_reset(1'b1);
    wait_retire(2, 30, cyc);
    checks++; if (cyc !== 7 || mem_addr !== 32'h40 || pc !== 32'h40) begin errors++; $display("FAIL bne_back: cyc=%0d addr=%h pc=%h, want 7 00000040 00000040", cyc, mem_addr, pc); end
  endtask

  task automatic test_stall();
    int cyc, c2, base;
    clear_mem();
    put(enc_i(OP_LW, 0, 4, 8));
    put(enc_i(OP_SW, 0, 4, 12));
    mem[2] = 32'h1234_ABCD;
    mem[3] = 32'h0;
    do_reset(1'b0);
    base = retire_cnt;
    cyc = 0;
    repeat (3) begin
      @(posedge clk);
      cyc++;
      #1;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RPC) begin errors++; $display("FAIL fetch_stall: req=%b we=%b addr=%h, want 1 0 %h", mem_req, mem_we, mem_addr, RPC); end
    end
    mem_ready = 1'b1;
    @(posedge clk); cyc++; #1;
    @(posedge clk); cyc++; #1;
    mem_ready = 1'b0;
    @(posedge clk); cyc++; #1;
    repeat (4) begin
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd8) begin errors++; $display("FAIL mem_stall: req=%b we=%b addr=%h, want 1 0 00000008", mem_req, mem_we, mem_addr); end
      if (cyc < 9) begin @(posedge clk); cyc++; #1; end
    end
    checks++; if (retire_cnt != base) begin errors++; $display("FAIL stall_retire: pulses=%0d, want 0", retire_cnt - base); end
    mem_ready = 1'b1;
    wait_retire(1, 20, c2);
    cyc += c2;
    checks++; if (cyc !== 11) begin errors++; $display("FAIL lw_stall_latency: cycles=%0d, want 11", cyc); end
    wait_retire(1, 20, c2);
    checks++; if (mem[3] !== 32'h1234_ABCD) begin errors++; $display("FAIL lw_stall_data: mem[12]=%h, want 1234abcd", mem[3]); end
  endtask

  task automatic test_corner();
    int cyc;
    clear_mem();
    put(enc_i(OP_ADDI, 0, 1, 7));
    put(enc_r(1, 1, 0, FN_ADD));
    put(enc_i(OP_SW, 0, 0, 16));
    put(enc_i(OP_ADDI, 0, 6, -1));
    put(enc_i(OP_ADDI, 0, 7, 1));
    put(enc_r(6, 7, 5, FN_SLT));
    put(enc_i(OP_SW, 0, 5, 20));
    put(enc_r(7, 6, 8, FN_SLT));
    put(enc_i(OP_SW, 0, 8, 24));
    put(enc_i(OP_LW, 0, 9, 28));
    put(enc_i(OP_ADDI, 0, 10, 1));
    put(enc_r(9, 10, 11, FN_ADD));
    put(enc_i(OP_SW, 0, 11, 32));
    put(enc_r(1, 6, 12, FN_SUB));
    put(enc_r(1, 7, 13, FN_AND));
    put(enc_r(1, 6, 14, FN_OR));
    put(enc_i(OP_SW, 0, 12, 36));
    put(enc_i(OP_SW, 0, 13, 40));
    put(enc_i(OP_SW, 0, 14, 44));
    mem[4] = 32'hDEAD_BEEF;
    mem[5] = 32'h5555_5555;
    mem[6] = 32'h6666_6666;
    mem[7] = 32'h7FFF_FFFF;
    exp_q = {32'h0, 32'h1, 32'h0, 32'h8000_0000, 32'h8, 32'h1, 32'hFFFF_FFFF};
    do_reset(1'b1);
    wait_retire(19, 200, cyc);
    checks++; if (cyc !== 77) begin errors++; $display("FAIL corner_latency: cycles=%0d, want 77", cyc); end
    checks++; if (wd_q.size() != exp_q.size()) begin errors++; $display("FAIL corner_nwrites: got %0d, want %0d", wd_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wd_q.size(); i++) begin
      checks++; if (wd_q[i] !== exp_q[i]) begin errors++; $display("FAIL corner_wdata[%0d]: got %h, want %h", i, wd_q[i], exp_q[i]); end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 32'h90) begin errors++; $display("FAIL corner_halt: halted=%b req=%b pc=%h, want 1 0 00000090", halted, mem_req, pc); end
  endtask

  task automatic test_halt();
    int base;
    clear_mem();
    do_reset(1'b1);
    base = retire_cnt;
    @(posedge clk); #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: halted=%b, want 0", halted); end
    @(posedge clk); #1;
    checks++; if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 32'h44 || dbg_state !== 3'd5) begin errors++; $display("FAIL halt_enter: halted=%b req=%b pc=%h state=%0d, want 1 0 00000044 5", halted, mem_req, pc, dbg_state); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 32'h44 || retire_cnt != base) begin errors++; $display("FAIL halt_hold: halted=%b req=%b pc=%h pulses=%0d, want 1 0 00000044 0", halted, mem_req, pc, retire_cnt - base); end
    reset = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || mem_req !== 1'b0 || pc !== RPC) begin errors++; $display("FAIL halt_reset: halted=%b req=%b pc=%h, want 0 0 %h", halted, mem_req, pc, RPC); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RPC) begin errors++; $display("FAIL halt_refetch: req=%b we=%b addr=%h, want 1 0 %h", mem_req, mem_we, mem_addr, RPC); end

    // R-type with an unsupported funct also halts.
    clear_mem();
    mem[16] = 32'h0022_1800;
    do_reset(1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (halted !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL halt_funct: halted=%b req=%b, want 1 0", halted, mem_req); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    clear_mem();
    put(enc_i(OP_ADDI, 0, 1, 9));
    put(enc_i(OP_SW, 0, 1, 12));
    mem[3] = 32'hAAAA_AAAA;
    do_reset(1'b1);
    wait_retire(1, 20, cyc);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd12 || mem_wdata !== 32'd9) begin errors++; $display("FAIL sw_request: req=%b we=%b addr=%h data=%h, want 1 1 0000000c 00000009", mem_req, mem_we, mem_addr, mem_wdata); end
    reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || pc !== RPC) begin errors++; $display("FAIL abort_reset: req=%b pc=%h, want 0 %h", mem_req, pc, RPC); end
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (wa_q.size() != 0 || mem[3] !== 32'hAAAA_AAAA) begin errors++; $display("FAIL abort_nowrite: writes=%0d mem[12]=%h, want 0 aaaaaaaa", wa_q.size(), mem[3]); end
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RPC) begin errors++; $display("FAIL abort_refetch: req=%b we=%b addr=%h, want 1 0 %h", mem_req, mem_we, mem_addr, RPC); end
    wait_retire(2, 30, cyc);
    checks++; if (cyc !== 8 || mem[3] !== 32'd9) begin errors++; $display("FAIL abort_rerun: cyc=%0d mem[12]=%h, want 8 00000009", cyc, mem[3]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    mem_ready = 1'b0;
    clear_mem();
    test_reset();
    test_program();
    test_branch();
    test_stall();
    test_corner();
    test_halt();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
